// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: scans a stored RGB444 frame out as a centred, padded VGA raster.
// Ports: clk_p/rst, all_ready, r_addr/r_data frame-memory read, vga_r/g/b, hsync/vsync, frame_start.
// Optional macro FRAME_BORDER_EN draws a 1-pixel white border around the image window.
module vga_frame_scanout #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 19,
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 300,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  all_ready,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int X0    = (H_VIS - IMG_W) / 2;
    localparam int Y0    = (V_VIS - IMG_H) / 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [HW-1:0] X_BEG    = HW'(X0);
    localparam logic [HW-1:0] X_END    = HW'(X0 + IMG_W - 1);
    localparam logic [VW-1:0] Y_BEG    = VW'(Y0);
    localparam logic [VW-1:0] Y_END    = VW'(Y0 + IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX =
        ADDR_WIDTH'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t                  state;
    logic [DW-1:0]           div;
    logic [HW-1:0]           hcnt;
    logic [VW-1:0]           vcnt;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic                    in_img_d;
    logic                    hs_d;
    logic                    vs_d;
    logic [DATA_WIDTH-1:0]   pix_nxt;

    logic tick;
    logic h_last;
    logic v_last;
    logic at_origin;
    logic in_img;
    logic go_idle;

    assign tick      = (state != IDLE) && (div == DIV_LAST);
    assign h_last    = (hcnt == H_LAST);
    assign v_last    = (vcnt == V_LAST);
    assign at_origin = (hcnt == '0) && (vcnt == '0);
    assign in_img    = (hcnt >= X_BEG) && (hcnt <= X_END) &&
                       (vcnt >= Y_BEG) && (vcnt <= Y_END);
    // Leaving DRAIN for IDLE reuses the reset path so the
    // half-flushed pipeline is discarded in one step.
    assign go_idle   = (state == DRAIN) && tick &&
                       h_last && v_last && !all_ready;

`ifdef FRAME_BORDER_EN
    localparam logic [HW-1:0] BX_L = HW'(X0 - 1);
    localparam logic [HW-1:0] BX_R = HW'(X0 + IMG_W);
    localparam logic [VW-1:0] BY_T = VW'(Y0 - 1);
    localparam logic [VW-1:0] BY_B = VW'(Y0 + IMG_H);

    logic on_brd;
    logic brd_d;

    assign on_brd =
        ((hcnt == BX_L || hcnt == BX_R) &&
         vcnt >= BY_T && vcnt <= BY_B) ||
        ((vcnt == BY_T || vcnt == BY_B) &&
         hcnt >= BX_L && hcnt <= BX_R);
`endif

    // Colour is only released while scanning; leaving SCAN
    // blanks the very next pixel even if it was already fetched.
    always_comb begin
        pix_nxt = '0;
        if (state == SCAN) begin
            if (in_img_d) begin
                pix_nxt = r_data;
            end
`ifdef FRAME_BORDER_EN
            else if (brd_d) begin
                pix_nxt = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst || go_idle) begin
            state       <= IDLE;
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            addr_cnt    <= '0;
            r_addr      <= '0;
            in_img_d    <= 1'b0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
`ifdef FRAME_BORDER_EN
            brd_d       <= 1'b0;
`endif
        end else begin
            frame_start <= 1'b0;

            unique case (state)
                IDLE:    if (all_ready) state <= SCAN;
                SCAN:    if (!all_ready) state <= DRAIN;
                DRAIN:   if (tick && h_last && v_last)
                             state <= SCAN;
                default: state <= IDLE;
            endcase

            if (state != IDLE) begin
                div <= tick ? '0 : div + DW'(1);
            end

            if (tick) begin
                hcnt <= h_last ? '0 : hcnt + HW'(1);
                if (h_last) begin
                    vcnt <= v_last ? '0 : vcnt + VW'(1);
                end

                // Running address instead of a row*width product;
                // r_addr only moves on image pixels.
                if (at_origin) begin
                    addr_cnt <= '0;
                end else if (in_img) begin
                    r_addr <= addr_cnt;
                    if (addr_cnt != ADDR_MAX) begin
                        addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                    end
                end

                in_img_d <= in_img && (state == SCAN);
                hs_d     <= !(hcnt >= HS_BEG && hcnt <= HS_END);
                vs_d     <= !(vcnt >= VS_BEG && vcnt <= VS_END);
`ifdef FRAME_BORDER_EN
                brd_d    <= on_brd && (state == SCAN);
`endif

                vga_r <= pix_nxt[11:8];
                vga_g <= pix_nxt[7:4];
                vga_b <= pix_nxt[3:0];
                hsync <= hs_d;
                vsync <= vs_d;

                frame_start <= (state == SCAN) && at_origin;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: randomized bench for vga_frame_scanout on a shrunken raster.
// Checks every clock against a pixel-index model plus literal pixel/timing expectations.
module tb_vga_frame_scanout;

    localparam int D  = 4;
    localparam int HV = 40;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VV = 30;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int IW = 20;
    localparam int IH = 16;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int X0 = (HV - IW) / 2;
    localparam int Y0 = (VV - IH) / 2;
    localparam int NPIX = IW * IH;
`ifdef FRAME_BORDER_EN
    localparam logic [11:0] BRD = 12'hFFF;
`else
    localparam logic [11:0] BRD = 12'h000;
`endif

    logic        clk_p = 1'b0;
    logic        rst = 1'b1;
    logic        all_ready = 1'b0;
    logic [18:0] r_addr;
    logic [11:0] r_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    vga_frame_scanout #(
        .DATA_WIDTH(12), .ADDR_WIDTH(19),
        .IMG_W(IW), .IMG_H(IH),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(D)
    ) dut (
        .clk_p(clk_p), .rst(rst), .all_ready(all_ready),
        .r_addr(r_addr), .r_data(r_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk_p = ~clk_p;

    // Frame memory: word = low 12 address bits, 1-clock read.
    always @(posedge clk_p) r_data <= r_addr[11:0];

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    function automatic logic [11:0] pix_exp(int h, int v);
        if (h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH)
            return 12'((v - Y0) * IW + h - X0);
`ifdef FRAME_BORDER_EN
        if ((h == X0 - 1 || h == X0 + IW) &&
            v >= Y0 - 1 && v <= Y0 + IH)
            return 12'hFFF;
        if ((v == Y0 - 1 || v == Y0 + IH) &&
            h >= X0 - 1 && h <= X0 + IW)
            return 12'hFFF;
`endif
        return 12'h000;
    endfunction

    // Address of the most recent image pixel fetched up to and
    // including raster pixel q (counted from scan start).
    function automatic int last_addr(int q);
        int f, h, v, row;
        f = q / FR;
        h = (q % FR) % HT;
        v = (q % FR) / HT;
        if (v >= Y0 + IH) return NPIX - 1;
        if (v >= Y0) begin
            row = v - Y0;
            if (h >= X0 + IW - 1) return row * IW + IW - 1;
            if (h >= X0) return row * IW + h - X0;
            if (row > 0) return row * IW - 1;
        end
        return (f > 0) ? NPIX - 1 : 0;
    endfunction

    // Model: m_st 0=idle 1=scan 2=drain; c = clocks since scan start.
    int m_st = 0;
    int c = 0;
    bit m_en = 0;
    bit m_fs = 0;

    bit cap_on = 0;
    logic [11:0] cap_first = 12'hAAA, cap_second = 12'hAAA;
    logic [11:0] cap_last = 12'hAAA, cap_bl = 12'hAAA;
    logic [11:0] cap_bt = 12'hAAA, cap_out = 12'hAAA;
    int hs_fall = -1, hs_per = -1, hs_low = -1;
    int vs_fall = -1, vs_low = -1;
    int fs_last = -1, fs_per = -1;
    int max_addr = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    always @(negedge clk_p) begin : model_chk
        int pre, q, k, p, h, v;
        bit tk;
        logic [11:0] e_col, d_col;
        logic [31:0] e_adr;
        logic e_hs, e_vs, e_fs;
        cyc++;
        pre = m_st;
        m_fs = 0;
        if (rst) begin
            m_st = 0; c = 0; m_en = 0;
        end else if (pre == 0) begin
            if (all_ready) begin
                m_st = 1; c = 0; m_en = 0;
            end
        end else begin
            c++;
            tk = (c % D) == 0;
            q = c / D - 1;
            if (tk) begin
                m_en = (pre == 1);
                m_fs = (pre == 1) && (q % FR == 0);
            end
            if (pre == 1 && !all_ready)
                m_st = 2;
            else if (pre == 2 && tk && (q % FR) == FR - 1)
                m_st = all_ready ? 1 : 0;
        end

        e_hs = 1'b1; e_vs = 1'b1; e_col = '0;
        e_adr = '0; e_fs = 1'b0;
        k = 0; h = 0; v = 0;
        if (m_st != 0) begin
            k = c / D;
            if (k >= 1) e_adr = 32'(last_addr(k - 1));
            if (k >= 2) begin
                p = k - 2;
                h = p % HT;
                v = (p / HT) % VT;
                e_hs = !(h >= HV + HF && h < HV + HF + HS);
                e_vs = !(v >= VV + VF && v < VV + VF + VS);
                if (m_en) e_col = pix_exp(h, v);
            end
            e_fs = m_fs;
        end
        d_col = {vga_r, vga_g, vga_b};
        chk("colour", 32'(d_col), 32'(e_col));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("r_addr", 32'(r_addr), e_adr);
        chk("frame_start", 32'(frame_start), 32'(e_fs));

        if (32'(r_addr) > 32'(max_addr)) max_addr = int'(r_addr);
        if (cap_on) begin
            if (prev_hs && !hsync) begin
                if (hs_fall >= 0) hs_per = cyc - hs_fall;
                hs_fall = cyc;
            end
            if (!prev_hs && hsync && hs_fall >= 0)
                hs_low = cyc - hs_fall;
            if (prev_vs && !vsync) vs_fall = cyc;
            if (!prev_vs && vsync && vs_fall >= 0)
                vs_low = cyc - vs_fall;
            if (frame_start) begin
                if (fs_last >= 0) fs_per = cyc - fs_last;
                fs_last = cyc;
            end
            if (m_st != 0 && k >= 2 && (c % D) == 0) begin
                if (h == X0 && v == Y0) cap_first = d_col;
                if (h == X0 + 1 && v == Y0) cap_second = d_col;
                if (h == X0 + IW - 1 && v == Y0 + IH - 1)
                    cap_last = d_col;
                if (h == X0 - 1 && v == 12) cap_bl = d_col;
                if (h == 15 && v == Y0 - 1) cap_bt = d_col;
                if (h == X0 - 2 && v == 12) cap_out = d_col;
            end
        end
        prev_hs = hsync;
        prev_vs = vsync;
    end

    initial begin
        int w;
        repeat (3) @(negedge clk_p);
        #1 rst = 1'b0;
        repeat (2000) @(negedge clk_p);

        #1 all_ready = 1'b1; cap_on = 1'b1;
        repeat (2 * FR * D + 400) @(negedge clk_p);
        #1 cap_on = 1'b0;
        chk("px_first", 32'(cap_first), 32'h000);
        chk("px_second", 32'(cap_second), 32'h001);
        chk("px_last", 32'(cap_last), 32'h13F);
        chk("border_left", 32'(cap_bl), 32'(BRD));
        chk("border_top", 32'(cap_bt), 32'(BRD));
        chk("outside_border", 32'(cap_out), 32'h000);
        chk("hsync_period", 32'(hs_per), 32'd224);
        chk("hsync_low", 32'(hs_low), 32'd24);
        chk("vsync_low", 32'(vs_low), 32'd448);
        chk("frame_period", 32'(fs_per), 32'd8288);

        w = $urandom_range(5000, 2000);
        repeat (w) @(negedge clk_p);
        #1 all_ready = 1'b0;
        w = $urandom_range(1500, 500);
        repeat (w) @(negedge clk_p);
        #1 all_ready = 1'b1;
        repeat (FR * D + 2000) @(negedge clk_p);

        #1 all_ready = 1'b0;
        repeat (FR * D + 500) @(negedge clk_p);
        #1 all_ready = 1'b1;
        w = $urandom_range(8000, 3000);
        repeat (w) @(negedge clk_p);
        #1 rst = 1'b1; all_ready = 1'b0;
        @(negedge clk_p);
        chk("rst_colour", 32'({vga_r, vga_g, vga_b}), 32'h0);
        chk("rst_syncs", 32'({hsync, vsync}), 32'h3);
        chk("rst_addr", 32'(r_addr), 32'h0);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk_p);
        #1 all_ready = 1'b1;
        repeat (FR * D + 500) @(negedge clk_p);

        chk("max_addr", 32'(max_addr), 32'd319);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
